// File: rtl/audio_rp_controller.sv
// audio_rp_controller: record/playback sequencer in front of a single-port
// 8-bit sample memory. The one memory port belongs to whichever state is
// active: writes while recording, reads while playing, parked at 0 in IDLE.
module audio_rp_controller #(
  parameter int ADDR_W   = 14,
  parameter int READ_LAT = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_record,
  input  logic              stop_record,
  input  logic              start_playback,
  input  logic              signal_12khz,
  input  logic [7:0]        mic_sample,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [7:0]        bram_din,
  input  logic [7:0]        bram_dout,
  output logic [7:0]        audio_out,
  output logic              recording,
  output logic              playing,
  output logic [ADDR_W:0]   rec_length,
  output logic              done
);

  localparam logic [7:0]      SILENCE   = 8'h80;
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  // Highest memory address, widened to pointer width for comparison.
  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W:0]     wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W:0]     rd_ptr_reg, rd_ptr_next;
  logic [ADDR_W:0]     rec_len_reg, rec_len_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                we_reg, we_next;
  logic [7:0]          din_reg, din_next;
  logic [7:0]          audio_reg, audio_next;
  logic                done_reg, done_next;
  logic                recording_reg, playing_reg;

  // Read-valid pipeline: stage k is high k+1 cycles after a read was issued,
  // so stage READ_LAT lines up with the cycle bram_dout carries the sample.
  logic [READ_LAT:0]   vld_reg, vld_next;
  logic                rd_issue;
  logic                restart;
  logic                pipe_flush;

  genvar gi;

  assign vld_next[0] = rd_issue;

  generate
    for (gi = 1; gi <= READ_LAT; gi++) begin : g_rd_pipe
      assign vld_next[gi] = vld_reg[gi-1] & ~pipe_flush;
    end
  endgenerate

  // Next-state, pointer and memory-port decisions for the current state.
  always_comb begin
    state_next   = state_reg;
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    rec_len_next = rec_len_reg;
    addr_next    = '0;
    we_next      = 1'b0;
    din_next     = din_reg;
    audio_next   = audio_reg;
    done_next    = 1'b0;
    rd_issue     = 1'b0;
    restart      = 1'b0;
    pipe_flush   = 1'b0;

    case (state_reg)
      IDLE: begin
        audio_next = SILENCE;
        if (start_record) begin
          state_next   = RECORD;
          wr_ptr_next  = '0;
          rec_len_next = '0;
        end else if (start_playback) begin
          if (rec_len_reg != '0) begin
            state_next  = PLAY;
            rd_ptr_next = '0;
          end else begin
            // Nothing to play: report completion immediately.
            done_next = 1'b1;
          end
        end
      end

      RECORD: begin
        audio_next = SILENCE;
        if (signal_12khz) begin
          we_next      = 1'b1;
          addr_next    = wr_ptr_reg[ADDR_W-1:0];
          din_next     = mic_sample;
          wr_ptr_next  = wr_ptr_reg + PTR_ONE;
          rec_len_next = wr_ptr_reg + PTR_ONE;
          // A stop or the last free slot ends the take on the write cycle.
          if (stop_record || (wr_ptr_reg == LAST_ADDR)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end else if (stop_record) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end

      PLAY: begin
        if (start_playback) begin
          restart     = 1'b1;
          rd_ptr_next = '0;
        end else begin
          if (vld_reg[READ_LAT]) begin
            audio_next = bram_dout;
          end
          if (signal_12khz) begin
            if (rd_ptr_reg == rec_len_reg) begin
              // Every sample has been played; this strobe ends playback.
              state_next = IDLE;
              done_next  = 1'b1;
              audio_next = SILENCE;
            end else begin
              rd_issue    = 1'b1;
              addr_next   = rd_ptr_reg[ADDR_W-1:0];
              rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
        audio_next = SILENCE;
      end
    endcase

    pipe_flush = restart | (state_next != PLAY);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rec_len_reg   <= '0;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      din_reg       <= 8'h00;
      audio_reg     <= SILENCE;
      done_reg      <= 1'b0;
      recording_reg <= 1'b0;
      playing_reg   <= 1'b0;
      vld_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      rec_len_reg   <= rec_len_next;
      addr_reg      <= addr_next;
      we_reg        <= we_next;
      din_reg       <= din_next;
      audio_reg     <= audio_next;
      done_reg      <= done_next;
      recording_reg <= (state_next == RECORD);
      playing_reg   <= (state_next == PLAY);
      vld_reg       <= vld_next;
    end
  end

  assign bram_addr  = addr_reg;
  assign bram_we    = we_reg;
  assign bram_din   = din_reg;
  assign audio_out  = audio_reg;
  assign recording  = recording_reg;
  assign playing    = playing_reg;
  assign rec_length = rec_len_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_audio_rp_controller.sv
// tb_audio_rp_controller: directed record / playback / boundary vectors
// against audio_rp_controller with an 8-entry, 2-cycle-latency memory model.
module tb_audio_rp_controller;

  localparam int ADDR_W   = 3;
  localparam int READ_LAT = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              start_record = 1'b0;
  logic              stop_record = 1'b0;
  logic              start_playback = 1'b0;
  logic              signal_12khz = 1'b0;
  logic [7:0]        mic_sample = 8'h00;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_we;
  logic [7:0]        bram_din;
  logic [7:0]        bram_dout;
  logic [7:0]        audio_out;
  logic              recording;
  logic              playing;
  logic [ADDR_W:0]   rec_length;
  logic              done;

  audio_rp_controller #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_record   (start_record),
    .stop_record    (stop_record),
    .start_playback (start_playback),
    .signal_12khz   (signal_12khz),
    .mic_sample     (mic_sample),
    .bram_addr      (bram_addr),
    .bram_we        (bram_we),
    .bram_din       (bram_din),
    .bram_dout      (bram_dout),
    .audio_out      (audio_out),
    .recording      (recording),
    .playing        (playing),
    .rec_length     (rec_length),
    .done           (done)
  );

  always #5 clk_in = ~clk_in;

  // Sample memory: registered address, then registered data (latency 2).
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] addr_d1;
  logic [7:0]        dout_reg;
  assign bram_dout = dout_reg;

  always @(posedge clk_in) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    addr_d1  <= bram_addr;
    dout_reg <= mem[addr_d1];
  end

  // Activity log: every write and every done pulse seen at a clock edge.
  int done_cnt = 0;
  int log_addr[$];
  int log_data[$];
  always @(posedge clk_in) begin
    if (done) done_cnt <= done_cnt + 1;
    if (bram_we) begin
      log_addr.push_back(int'(bram_addr));
      log_data.push_back(int'(bram_din));
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Snapshot of outputs one cycle after a strobe.
  logic              s_we, s_done, s_rec, s_play;
  logic [ADDR_W-1:0] s_addr;
  logic [7:0]        s_din, s_audio;
  logic [ADDR_W:0]   s_len;

  task automatic strobe(input logic [7:0] s, input logic stop);
    signal_12khz = 1'b1;
    mic_sample   = s;
    stop_record  = stop;
    tick();
    signal_12khz = 1'b0;
    stop_record  = 1'b0;
    s_we = bram_we; s_addr = bram_addr; s_din = bram_din; s_done = done;
    s_rec = recording; s_play = playing; s_len = rec_length; s_audio = audio_out;
    repeat (4) tick();
  endtask

  logic [7:0] exp8 [0:2];
  int base_done;
  int base_wr;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp8[0] = 8'h10; exp8[1] = 8'h20; exp8[2] = 8'h30;

    // Reset state
    repeat (3) tick();
    check("rst_we", bram_we, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_din", bram_din, 0);
    check("rst_audio", audio_out, 8'h80);
    check("rst_rec", recording, 0);
    check("rst_play", playing, 0);
    check("rst_len", rec_length, 0);
    check("rst_done", done, 0);
    rst_in = 1'b0;
    tick();

    // Empty playback
    start_playback = 1'b1; tick(); start_playback = 1'b0;
    check("empty_done", done, 1);
    check("empty_play", playing, 0);
    check("empty_audio", audio_out, 8'h80);
    tick();
    check("empty_done_off", done, 0);
    check("empty_play2", playing, 0);

    // Record three samples then stop
    base_done = done_cnt; base_wr = log_addr.size();
    start_record = 1'b1; tick(); start_record = 1'b0;
    check("rec_state", recording, 1);
    check("rec_len_clr", rec_length, 0);
    strobe(8'h10, 1'b0);
    check("wr0_we", s_we, 1);
    check("wr0_addr", s_addr, 0);
    check("wr0_din", s_din, 8'h10);
    check("wr0_len", s_len, 1);
    check("wr0_we_off", bram_we, 0);
    strobe(8'h20, 1'b0);
    strobe(8'h30, 1'b0);
    check("rec_len3", rec_length, 3);
    check("rec_still", recording, 1);
    stop_record = 1'b1; tick(); stop_record = 1'b0;
    check("stop_done", done, 1);
    check("stop_idle", recording, 0);
    check("stop_audio", audio_out, 8'h80);
    tick();
    check("rec_done_cnt", done_cnt - base_done, 1);
    check("rec_wr_cnt", log_addr.size() - base_wr, 3);
    for (int i = 0; i < 3; i++) begin
      if (base_wr + i < log_addr.size()) begin
        check("rec_wr_addr", log_addr[base_wr+i], i);
        check("rec_wr_data", log_data[base_wr+i], exp8[i]);
      end
    end

    // Play it back
    base_done = done_cnt;
    start_playback = 1'b1; tick(); start_playback = 1'b0;
    check("pb_play", playing, 1);
    check("pb_audio0", audio_out, 8'h80);
    for (int i = 0; i < 3; i++) begin
      strobe(8'h00, 1'b0);
      check("pb_addr", s_addr, i);
      check("pb_hold", s_audio, (i == 0) ? 8'h80 : exp8[(i == 0) ? 0 : i-1]);
      check("pb_audio", audio_out, exp8[i]);
    end
    strobe(8'h00, 1'b0);
    check("pb_end_done", s_done, 1);
    check("pb_end_audio", s_audio, 8'h80);
    check("pb_end_play", s_play, 0);
    check("pb_done_cnt", done_cnt - base_done, 1);
    check("pb_len_kept", rec_length, 3);

    // Stop coincident with a strobe
    base_done = done_cnt; base_wr = log_addr.size();
    start_record = 1'b1; tick(); start_record = 1'b0;
    strobe(8'hAA, 1'b0);
    strobe(8'hBB, 1'b1);
    check("co_we", s_we, 1);
    check("co_addr", s_addr, 1);
    check("co_din", s_din, 8'hBB);
    check("co_done", s_done, 1);
    check("co_rec", s_rec, 0);
    check("co_len", s_len, 2);
    check("co_done_cnt", done_cnt - base_done, 1);
    check("co_wr_cnt", log_addr.size() - base_wr, 2);

    // Restart mid-play, then reset mid-play
    base_done = done_cnt;
    start_playback = 1'b1; tick(); start_playback = 1'b0;
    strobe(8'h00, 1'b0);
    check("rs_audio0", audio_out, 8'hAA);
    strobe(8'h00, 1'b0);
    check("rs_audio1", audio_out, 8'hBB);
    start_playback = 1'b1; tick(); start_playback = 1'b0;
    check("rs_play", playing, 1);
    strobe(8'h00, 1'b0);
    check("rs_addr", s_addr, 0);
    check("rs_audio", audio_out, 8'hAA);
    check("rs_no_done", done_cnt - base_done, 0);
    signal_12khz = 1'b1; tick(); signal_12khz = 1'b0;
    rst_in = 1'b1; tick();
    check("mr_audio", audio_out, 8'h80);
    check("mr_len", rec_length, 0);
    check("mr_play", playing, 0);
    check("mr_done", done, 0);
    rst_in = 1'b0;
    repeat (4) tick();
    check("mr_no_done", done_cnt - base_done, 0);
    check("mr_audio2", audio_out, 8'h80);

    // Fill memory: both starts together, record wins
    base_done = done_cnt; base_wr = log_addr.size();
    start_record = 1'b1; start_playback = 1'b1; tick();
    start_record = 1'b0; start_playback = 1'b0;
    check("both_rec", recording, 1);
    check("both_play", playing, 0);
    for (int i = 0; i < 8; i++) begin
      strobe(8'(8'h40 + i), 1'b0);
      check("full_addr", s_addr, i);
      if (i == 3) begin
        start_playback = 1'b1; tick(); start_playback = 1'b0;
        check("rec_ign_pb", playing, 0);
        check("rec_ign_rec", recording, 1);
        repeat (3) tick();
      end
    end
    check("full_we", s_we, 1);
    check("full_din", s_din, 8'h47);
    check("full_done", s_done, 1);
    check("full_rec", s_rec, 0);
    check("full_len", s_len, 8);
    strobe(8'h99, 1'b0);
    check("full_9th_we", s_we, 0);
    check("full_wr_cnt", log_addr.size() - base_wr, 8);
    check("full_done_cnt", done_cnt - base_done, 1);
    check("full_len_kept", rec_length, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_rp_controller.md
AUDIO_RP_CONTROLLER -- requirements
Module: audio_rp_controller

Interface
REQ-001 Parameter ADDR_W, default 14: sample-memory address width; capacity 2^ADDR_W 8-bit samples.
REQ-002 Parameter READ_LAT, default 2: BRAM read latency in clk_in cycles.
REQ-003 clk_in  input  1  system clock, 100 MHz; single clock domain.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 start_record  input  1  single-cycle pulse; begin a new recording.
REQ-006 stop_record  input  1  single-cycle pulse; end the recording.
REQ-007 start_playback  input  1  single-cycle pulse; play the stored recording from sample 0.
REQ-008 signal_12khz  input  1  single-cycle sample strobe; consecutive strobes are always at least READ_LAT+2 cycles apart.
REQ-009 mic_sample  input  8  unsigned sample to record; valid whenever signal_12khz is high.
REQ-010 bram_addr  output  ADDR_W  sample-memory address.
REQ-011 bram_we  output  1  sample-memory write enable.
REQ-012 bram_din  output  8  sample-memory write data.
REQ-013 bram_dout  input  8  sample-memory read data, valid READ_LAT cycles after the address is presented.
REQ-014 audio_out  output  8  unsigned playback sample; 8'h80 is silence.
REQ-015 recording  output  1  high while in RECORD.
REQ-016 playing  output  1  high while in PLAY.
REQ-017 rec_length  output  ADDR_W+1  number of valid stored samples.
REQ-018 done  output  1  single-cycle pulse at the end of a recording or playback.

Function
REQ-019 States: IDLE, RECORD, PLAY; the block has exactly one memory port, and it is owned by the current state.
REQ-020 IDLE + start_record -> RECORD next cycle; write pointer and rec_length cleared to 0.
REQ-021 IDLE + start_playback with rec_length>0 -> PLAY next cycle; read pointer cleared to 0.
REQ-022 IDLE + start_playback with rec_length=0: stay in IDLE; done pulses on the next cycle.
REQ-023 start_record and start_playback together in IDLE: record wins.
REQ-024 RECORD, per strobe:
- Next cycle: bram_we=1 for exactly one cycle, bram_addr=write pointer, bram_din=mic_sample captured at the strobe.
- Write pointer increments; rec_length = write pointer + 1.
REQ-025 RECORD, memory full: after the write to address 2^ADDR_W-1, rec_length=2^ADDR_W, state -> IDLE, done pulses, and no write wraps to address 0.
REQ-026 RECORD + stop_record -> IDLE with a done pulse. If stop_record coincides with a strobe, that sample is written first, then IDLE and done follow on the write cycle.
REQ-027 start_playback in RECORD, and start_record in PLAY, are ignored.
REQ-028 PLAY, per strobe:
- Next cycle: bram_addr=read pointer.
- READ_LAT cycles later: audio_out is loaded from bram_dout and held until the next load.
- Read pointer increments.
REQ-029 PLAY end: after audio_out is loaded with sample rec_length-1, it holds that value until the next strobe; on that strobe audio_out=8'h80, state -> IDLE, done pulses.
REQ-030 PLAY + start_playback: restart; read pointer=0, any in-flight read is discarded, and no done pulse occurs.
REQ-031 bram_we=0 outside RECORD write cycles.
REQ-032 bram_addr=0 in IDLE.
REQ-033 audio_out=8'h80 whenever not in PLAY.
REQ-034 rec_length holds its value across IDLE and PLAY; it changes only in RECORD or on reset.
REQ-035 recording and playing are registered decodes of the state and are never both high.

Reset
REQ-036 While rst_in is high at a clk_in edge: state=IDLE, bram_we=0, bram_addr=0, bram_din=0, audio_out=8'h80, recording=0, playing=0, rec_length=0, done=0.
REQ-037 Reset mid-RECORD or mid-PLAY aborts the operation, suppresses done, and discards the recording (rec_length=0).

Verification
REQ-038 Record: start_record, 3 strobes with mic_sample=8'h10,8'h20,8'h30, then stop_record -> writes at addresses 0,1,2 with those values; rec_length=3; one done pulse.
REQ-039 Playback: after REQ-038, start_playback then 4 strobes, with a BRAM model of latency 2 -> audio_out=8'h10,8'h20,8'h30, then 8'h80; one done pulse on the 4th strobe.
REQ-040 Empty: reset, then start_playback -> playing stays 0, done pulses after 1 cycle, audio_out=8'h80.
REQ-041 Full: ADDR_W=3, record 9 strobes -> 8 writes (addresses 0..7), rec_length=8, done after the 8th write, 9th strobe ignored.
REQ-042 Boundary: stop_record coincident with a strobe -> that sample is written. rst_in mid-PLAY -> audio_out=8'h80, rec_length=0, no done.
